hazard_unit: RTL and testbench
==============================

# hazard_unit

Tracks the destination registers of in-flight instructions from decode through writeback and resolves the hazards this creates in the five-stage pipeline. It consumes the decoded control bits the controller produces in D, so it always knows what is pending in E, M and W. Each cycle it drives forwarding selects, stall and flush signals back to the datapath.

## Interface
Parameters:
- `REG_W`, default 5: register specifier width.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `valid_d`  in  1  D holds a real instruction (not a bubble).
- `rs_d`, `rt_d`  in  REG_W each  D-stage source specifiers.
- `uses_rs_d`, `uses_rt_d`  in  1 each  the D instruction actually reads rs / rt.
- `wreg_d`  in  REG_W  D-stage destination, regdst already applied.
- `regwrite_d`, `memtoreg_d`, `branch_d`  in  1 each  decoded controls for the D instruction.
- `pcsrc_m`  in  1  taken branch resolved in M. Present only without `HAZ_EARLY_BRANCH_EN`.
- `pcsrc_d`  in  1  taken branch resolved in D. Present only with `HAZ_EARLY_BRANCH_EN`.
- `stall_f`, `stall_d`  out  1 each  hold the PC / hold the F→D register.
- `flush_d`, `flush_e`, `flush_m`  out  1 each  bubble into D / E / M at the next edge.
- `fwd_a_e`, `fwd_b_e`  out  2 each  E-stage operand select: 00 register file, 01 W result, 10 M ALU result.
- `fwd_a_d`, `fwd_b_d`  out  1 each  D-stage comparator forward from M. Present only with the macro.

## Operation
- Internal record per stage E, M, W holds `valid`, `regwrite`, `memtoreg`, `wreg`. E additionally holds `rs`, `rt`. All records advance D→E→M→W every cycle; there is no enable.
- `flush_e` loads a bubble (valid=0, regwrite=0) into E. `flush_m` does the same for M.
- A match requires all of: the producer stage is valid, its `regwrite`=1, its `wreg` ≠ 0, its `wreg` equals the source, and the consumer's `uses_*` bit is set. Register 0 never matches.
- **Forwarding, E stage:** `fwd_a_e`=10 on a match of `rs_e` against M. Otherwise 01 on a match against W. Otherwise 00. M has priority over W. `fwd_b_e` follows the same rule with `rt_e`.
- **Load-use:** E holds a load (memtoreg=1) whose destination matches `rs_d` or `rt_d`. Then `stall_f`=`stall_d`=`flush_e`=1.
- **Branch, macro off:** `pcsrc_m`=1 asserts `flush_d`, `flush_e` and `flush_m`. It also forces `stall_f`=`stall_d`=0, overriding any load-use stall.
- **Branch, macro on:** see Configuration.
- **Reset:**
  - At the reset edge, all stage records clear to valid=0.
  - While `reset`=1, all outputs are forced to 0.
  - The first cycle after reset: all outputs are 0 unless D inputs alone cause `flush_d`.

## Timing
- All outputs are combinational from the current stage records plus the D inputs. They are consumed at the next `clk` edge. There is no added latency.
- A load-use stall lasts exactly one cycle. At the following edge the load moves to M, the match clears, and `fwd_*_e` then selects W (01) one cycle later.
- A taken branch resolved in M costs 3 cycles. The F, D and E instructions are squashed.
- Simultaneous load-use and `pcsrc_m`: the branch wins. No stall, all three flushes.
- Back-to-back producers to the same register: the younger one (M) is forwarded.

## Configuration
- `HAZ_EARLY_BRANCH_EN` defined: branches resolve in D.
  - `branch_d` with a match of rs_d/rt_d against E (any regwrite) → stall one cycle.
  - `branch_d` with a match against M where M memtoreg=1 → stall one cycle.
  - `fwd_a_d` / `fwd_b_d` = match against M where memtoreg=0.
  - `pcsrc_d` → `flush_d` only; penalty 1 cycle.
  - `flush_m` is tied to 0.
  - The `pcsrc_m` port is absent.
- Macro undefined: M-stage resolution as described in Operation. `fwd_*_d` and `pcsrc_d` are absent.

## Structure
- `hazard_pkg`: `FWD_RF`=2'b00, `FWD_WB`=2'b01, `FWD_MEM`=2'b10, `REG_ZERO`, and a packed stage-record typedef.
- Sub-module `hazard_stage_reg`: one stage record with synchronous `reset` and a `flush` input. Instantiated three times (E, M, W); E carries rs/rt.

## Test plan
- R-type writes $8, immediately followed by `add $9,$8,$8`: next cycle `fwd_a_e`=`fwd_b_e`=10. With one instruction between them: both 01.
- `lw $8`, then `add $9,$8,$0` in D: one cycle with `stall_f`=`stall_d`=`flush_e`=1, then `fwd_a_e`=01 and `fwd_b_e`=00.
- Writes to $0 followed by reads of $0: no stall, all forwards 00.
- Macro off: `pcsrc_m`=1 in the same cycle as a load-use condition → `flush_d`=`flush_e`=`flush_m`=1, `stall_f`=0.
- Macro on: `add $8` then `beq $8,$9` → one-cycle stall, then `fwd_a_d`=1. `pcsrc_d`=1 → `flush_d`=1 only.
- Assert `reset` for one cycle mid-stream with a pending load-use: outputs 0 during reset. After reset, no stale forwards or stalls from the pre-reset records.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared forwarding encodings, stage-record type and register-match helper
// for the hazard unit (optional HAZ_EARLY_BRANCH_EN lives in hazard_unit).
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int unsigned REG_ZERO = 0;

  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memtoreg;
  } stage_ctrl_t;

  localparam stage_ctrl_t BUBBLE = '0;

  // Register 0 is hardwired, so a write to it can never feed a reader.
  function automatic logic reg_match(stage_ctrl_t prod, logic [31:0] wreg,
                                     logic [31:0] src, logic uses);
    return prod.valid && prod.regwrite && (wreg != REG_ZERO) &&
           (wreg == src) && uses;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline stage record (valid/regwrite/memtoreg/wreg, optionally rs/rt)
// with synchronous reset and a flush that loads a bubble.
module hazard_stage_reg
  import hazard_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter bit HAS_SRC = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  stage_ctrl_t       ctrl_in,
  input  logic [REG_W-1:0]  wreg_in,
  input  logic [REG_W-1:0]  rs_in,
  input  logic [REG_W-1:0]  rt_in,
  output stage_ctrl_t       ctrl_q,
  output logic [REG_W-1:0]  wreg_q,
  output logic [REG_W-1:0]  rs_q,
  output logic [REG_W-1:0]  rt_q
);

  stage_ctrl_t      ctrl_d;
  logic [REG_W-1:0] wreg_d;

  always_comb begin
    ctrl_d = flush ? BUBBLE : ctrl_in;
    wreg_d = flush ? '0 : wreg_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= BUBBLE;
      wreg_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      wreg_q <= wreg_d;
    end
  end

  generate
    if (HAS_SRC) begin : g_src
      logic [REG_W-1:0] rs_d;
      logic [REG_W-1:0] rt_d;

      always_comb begin
        rs_d = flush ? '0 : rs_in;
        rt_d = flush ? '0 : rt_in;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          rs_q <= '0;
          rt_q <= '0;
        end else begin
          rs_q <= rs_d;
          rt_q <= rt_d;
        end
      end
    end else begin : g_no_src
      logic unused_src;
      assign unused_src = ^{rs_in, rt_in};
      assign rs_q = '0;
      assign rt_q = '0;
    end
  endgenerate

endmodule

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard unit: E-stage forwarding, load-use stall and
// branch flush. Define HAZ_EARLY_BRANCH_EN to resolve branches in D.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_d,
  input  logic [REG_W-1:0]  rs_d,
  input  logic [REG_W-1:0]  rt_d,
  input  logic              uses_rs_d,
  input  logic              uses_rt_d,
  input  logic [REG_W-1:0]  wreg_d,
  input  logic              regwrite_d,
  input  logic              memtoreg_d,
  input  logic              branch_d,
`ifdef HAZ_EARLY_BRANCH_EN
  input  logic              pcsrc_d,
`else
  input  logic              pcsrc_m,
`endif
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e
`ifdef HAZ_EARLY_BRANCH_EN
  ,
  output logic              fwd_a_d,
  output logic              fwd_b_d
`endif
);

  stage_ctrl_t      ctrl_in, ctrl_e, ctrl_m, ctrl_w;
  logic [REG_W-1:0] wreg_e, wreg_m, wreg_w;
  logic [REG_W-1:0] rs_e, rt_e;
  logic [REG_W-1:0] src_rs_d, src_rt_d;
  logic [REG_W-1:0] unused_rs_m, unused_rt_m, unused_rs_w, unused_rt_w;
  logic             unused_ok;

  logic m_rs_e, m_rt_e, w_rs_e, w_rt_e;
  logic e_rs_d, e_rt_d, mm_rs_d, mm_rt_d;
  logic load_use;

  // A source the instruction does not read is stored as register 0,
  // which can never match, so E needs no separate uses bits.
  always_comb begin
    ctrl_in  = '{valid: valid_d, regwrite: regwrite_d, memtoreg: memtoreg_d};
    src_rs_d = uses_rs_d ? rs_d : '0;
    src_rt_d = uses_rt_d ? rt_d : '0;
  end

  hazard_stage_reg #(.REG_W(REG_W), .HAS_SRC(1'b1)) u_stage_e (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush_e),
    .ctrl_in (ctrl_in),
    .wreg_in (wreg_d),
    .rs_in   (src_rs_d),
    .rt_in   (src_rt_d),
    .ctrl_q  (ctrl_e),
    .wreg_q  (wreg_e),
    .rs_q    (rs_e),
    .rt_q    (rt_e)
  );

  hazard_stage_reg #(.REG_W(REG_W), .HAS_SRC(1'b0)) u_stage_m (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush_m),
    .ctrl_in (ctrl_e),
    .wreg_in (wreg_e),
    .rs_in   ('0),
    .rt_in   ('0),
    .ctrl_q  (ctrl_m),
    .wreg_q  (wreg_m),
    .rs_q    (unused_rs_m),
    .rt_q    (unused_rt_m)
  );

  hazard_stage_reg #(.REG_W(REG_W), .HAS_SRC(1'b0)) u_stage_w (
    .clk     (clk),
    .reset   (reset),
    .flush   (1'b0),
    .ctrl_in (ctrl_m),
    .wreg_in (wreg_m),
    .rs_in   ('0),
    .rt_in   ('0),
    .ctrl_q  (ctrl_w),
    .wreg_q  (wreg_w),
    .rs_q    (unused_rs_w),
    .rt_q    (unused_rt_w)
  );

  always_comb begin
    m_rs_e  = reg_match(ctrl_m, 32'(wreg_m), 32'(rs_e), 1'b1);
    m_rt_e  = reg_match(ctrl_m, 32'(wreg_m), 32'(rt_e), 1'b1);
    w_rs_e  = reg_match(ctrl_w, 32'(wreg_w), 32'(rs_e), 1'b1);
    w_rt_e  = reg_match(ctrl_w, 32'(wreg_w), 32'(rt_e), 1'b1);
    e_rs_d  = reg_match(ctrl_e, 32'(wreg_e), 32'(rs_d), uses_rs_d);
    e_rt_d  = reg_match(ctrl_e, 32'(wreg_e), 32'(rt_d), uses_rt_d);
    mm_rs_d = reg_match(ctrl_m, 32'(wreg_m), 32'(rs_d), uses_rs_d);
    mm_rt_d = reg_match(ctrl_m, 32'(wreg_m), 32'(rt_d), uses_rt_d);
    load_use = ctrl_e.memtoreg && (e_rs_d || e_rt_d);
  end

  // Everything is held at zero while reset is asserted.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    fwd_a_e = FWD_RF;
    fwd_b_e = FWD_RF;
`ifdef HAZ_EARLY_BRANCH_EN
    fwd_a_d = 1'b0;
    fwd_b_d = 1'b0;
`endif
    if (!reset) begin
      fwd_a_e = m_rs_e ? FWD_MEM : (w_rs_e ? FWD_WB : FWD_RF);
      fwd_b_e = m_rt_e ? FWD_MEM : (w_rt_e ? FWD_WB : FWD_RF);
`ifdef HAZ_EARLY_BRANCH_EN
      stall_f = load_use ||
                (branch_d && (e_rs_d || e_rt_d ||
                              (ctrl_m.memtoreg && (mm_rs_d || mm_rt_d))));
      stall_d = stall_f;
      flush_e = stall_f;
      flush_d = pcsrc_d;
      fwd_a_d = mm_rs_d && !ctrl_m.memtoreg;
      fwd_b_d = mm_rt_d && !ctrl_m.memtoreg;
`else
      stall_f = load_use && !pcsrc_m;
      stall_d = stall_f;
      flush_e = load_use || pcsrc_m;
      flush_d = pcsrc_m;
      flush_m = pcsrc_m;
`endif
    end
  end

`ifdef HAZ_EARLY_BRANCH_EN
  assign unused_ok = ^{ctrl_w.memtoreg, unused_rs_m, unused_rt_m,
                       unused_rs_w, unused_rt_w};
`else
  assign unused_ok = ^{ctrl_w.memtoreg, branch_d, mm_rs_d, mm_rt_d,
                       unused_rs_m, unused_rt_m, unused_rs_w, unused_rt_w};
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed hazard scenarios plus random
// instruction streams against a pipeline-occupancy model (HAZ_EARLY_BRANCH_EN aware).
module tb_hazard_unit;

  localparam int REG_W = 5;

  typedef struct {
    bit v;
    bit rw;
    bit mtr;
    int wreg;
    int rs;
    int rt;
    bit urs;
    bit urt;
  } inst_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             valid_d;
  logic [REG_W-1:0] rs_d, rt_d, wreg_d;
  logic             uses_rs_d, uses_rt_d;
  logic             regwrite_d, memtoreg_d, branch_d;
  logic             pc_in;
  logic             stall_f, stall_d, flush_d, flush_e, flush_m;
  logic [1:0]       fwd_a_e, fwd_b_e;
`ifdef HAZ_EARLY_BRANCH_EN
  logic             fwd_a_d, fwd_b_d;
`endif

  hazard_unit #(.REG_W(REG_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_d    (valid_d),
    .rs_d       (rs_d),
    .rt_d       (rt_d),
    .uses_rs_d  (uses_rs_d),
    .uses_rt_d  (uses_rt_d),
    .wreg_d     (wreg_d),
    .regwrite_d (regwrite_d),
    .memtoreg_d (memtoreg_d),
    .branch_d   (branch_d),
`ifdef HAZ_EARLY_BRANCH_EN
    .pcsrc_d    (pc_in),
`else
    .pcsrc_m    (pc_in),
`endif
    .stall_f    (stall_f),
    .stall_d    (stall_d),
    .flush_d    (flush_d),
    .flush_e    (flush_e),
    .flush_m    (flush_m),
    .fwd_a_e    (fwd_a_e),
    .fwd_b_e    (fwd_b_e)
`ifdef HAZ_EARLY_BRANCH_EN
    ,
    .fwd_a_d    (fwd_a_d),
    .fwd_b_d    (fwd_b_d)
`endif
  );

  int checks = 0;
  int errors = 0;

  inst_t stg[3];
  inst_t cur;
  inst_t bubble_i;
  bit    cur_br, cur_pc, cur_rst;
  bit    e_stall, e_fd, e_fe, e_fm, e_fad, e_fbd;
  bit [1:0] e_fa, e_fb;

  function automatic inst_t mk(bit v, int rs, int rt, bit urs, bit urt,
                               int wreg, bit rw, bit mtr);
    inst_t i;
    i.v = v; i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt;
    i.wreg = wreg; i.rw = rw; i.mtr = mtr;
    return i;
  endfunction

  // True when instruction p will write register r that a reader actually uses.
  function automatic bit writes(inst_t p, int r, bit uses);
    return uses && p.v && p.rw && (p.wreg != 0) && (p.wreg == r);
  endfunction

  task automatic checkSig(string tag, logic [1:0] obs, logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(inst_t ins, bit br, bit pcs, bit rst);
    cur = ins; cur_br = br; cur_pc = pcs; cur_rst = rst;
    reset      = rst;
    valid_d    = ins.v;
    rs_d       = REG_W'(ins.rs);
    rt_d       = REG_W'(ins.rt);
    uses_rs_d  = ins.urs;
    uses_rt_d  = ins.urt;
    wreg_d     = REG_W'(ins.wreg);
    regwrite_d = ins.rw;
    memtoreg_d = ins.mtr;
    branch_d   = br;
    pc_in      = pcs;
  endtask

  task automatic checkOutput();
    inst_t e, m, w;
    bit lu, bs;
    e = stg[0]; m = stg[1]; w = stg[2];
    lu = e.mtr && (writes(e, cur.rs, cur.urs) || writes(e, cur.rt, cur.urt));
    e_fa = writes(m, e.rs, e.urs) ? 2'b10 : (writes(w, e.rs, e.urs) ? 2'b01 : 2'b00);
    e_fb = writes(m, e.rt, e.urt) ? 2'b10 : (writes(w, e.rt, e.urt) ? 2'b01 : 2'b00);
`ifdef HAZ_EARLY_BRANCH_EN
    bs = cur_br && (writes(e, cur.rs, cur.urs) || writes(e, cur.rt, cur.urt) ||
                    (m.mtr && (writes(m, cur.rs, cur.urs) || writes(m, cur.rt, cur.urt))));
    e_stall = lu || bs;
    e_fe = e_stall;
    e_fd = cur_pc;
    e_fm = 1'b0;
    e_fad = writes(m, cur.rs, cur.urs) && !m.mtr;
    e_fbd = writes(m, cur.rt, cur.urt) && !m.mtr;
`else
    bs = 1'b0;
    e_stall = lu && !cur_pc;
    e_fe = lu || cur_pc;
    e_fd = cur_pc;
    e_fm = cur_pc;
    e_fad = 1'b0;
    e_fbd = bs;
`endif
    if (cur_rst) begin
      e_stall = 0; e_fd = 0; e_fe = 0; e_fm = 0;
      e_fa = 2'b00; e_fb = 2'b00; e_fad = 0; e_fbd = 0;
    end
    checkSig("stall_f", {1'b0, stall_f}, {1'b0, e_stall});
    checkSig("stall_d", {1'b0, stall_d}, {1'b0, e_stall});
    checkSig("flush_d", {1'b0, flush_d}, {1'b0, e_fd});
    checkSig("flush_e", {1'b0, flush_e}, {1'b0, e_fe});
    checkSig("flush_m", {1'b0, flush_m}, {1'b0, e_fm});
    checkSig("fwd_a_e", fwd_a_e, e_fa);
    checkSig("fwd_b_e", fwd_b_e, e_fb);
`ifdef HAZ_EARLY_BRANCH_EN
    checkSig("fwd_a_d", {1'b0, fwd_a_d}, {1'b0, e_fad});
    checkSig("fwd_b_d", {1'b0, fwd_b_d}, {1'b0, e_fbd});
`endif
  endtask

  // Clock edge: the pipeline advances one slot, honouring the expected flushes.
  task automatic tick();
    @(posedge clk);
    if (cur_rst) begin
      for (int i = 0; i < 3; i++) stg[i] = bubble_i;
    end else begin
      stg[2] = stg[1];
      stg[1] = e_fm ? bubble_i : stg[0];
      stg[0] = e_fe ? bubble_i : cur;
    end
    #1;
  endtask

  task automatic step(inst_t ins, bit br, bit pcs, bit rst);
    applyStimulus(ins, br, pcs, rst);
    @(negedge clk);
    checkOutput();
    tick();
  endtask

  initial begin
    inst_t nop, ins;
    bubble_i = mk(0, 0, 0, 0, 0, 0, 0, 0);
    nop = bubble_i;
    for (int i = 0; i < 3; i++) stg[i] = bubble_i;

    step(nop, 0, 0, 1);
    step(mk(1, 3, 4, 1, 1, 8, 1, 0), 0, 0, 1);

    // add $8 then add $9,$8,$8: M forwarding on both operands
    step(mk(1, 1, 2, 1, 1, 8, 1, 0), 0, 0, 0);
    step(mk(1, 8, 8, 1, 1, 9, 1, 0), 0, 0, 0);
    applyStimulus(nop, 0, 0, 0);
    @(negedge clk); checkOutput();
    checkSig("tp_fwd_a_mem", fwd_a_e, 2'b10);
    checkSig("tp_fwd_b_mem", fwd_b_e, 2'b10);
    tick();

    // one instruction between producer and consumer: W forwarding
    step(mk(1, 1, 2, 1, 1, 10, 1, 0), 0, 0, 0);
    step(nop, 0, 0, 0);
    step(mk(1, 10, 10, 1, 1, 11, 1, 0), 0, 0, 0);
    applyStimulus(nop, 0, 0, 0);
    @(negedge clk); checkOutput();
    checkSig("tp_fwd_a_wb", fwd_a_e, 2'b01);
    checkSig("tp_fwd_b_wb", fwd_b_e, 2'b01);
    tick();

    // lw $8 then add $9,$8,$0: one stall, then W forward on A only
    step(mk(1, 2, 0, 1, 0, 8, 1, 1), 0, 0, 0);
    ins = mk(1, 8, 0, 1, 1, 9, 1, 0);
    applyStimulus(ins, 0, 0, 0);
    @(negedge clk); checkOutput();
    checkSig("tp_lu_stall", {stall_f, flush_e}, 2'b11);
    tick();
    applyStimulus(ins, 0, 0, 0);
    @(negedge clk); checkOutput();
    checkSig("tp_lu_release", {1'b0, stall_d}, 2'b00);
    tick();
    applyStimulus(nop, 0, 0, 0);
    @(negedge clk); checkOutput();
    checkSig("tp_lu_fwd_a", fwd_a_e, 2'b01);
    checkSig("tp_lu_fwd_b", fwd_b_e, 2'b00);
    tick();

    // writes to $0 never create a hazard
    step(mk(1, 1, 2, 1, 1, 0, 1, 1), 0, 0, 0);
    applyStimulus(mk(1, 0, 0, 1, 1, 5, 1, 0), 0, 0, 0);
    @(negedge clk); checkOutput();
    checkSig("tp_r0_nostall", {1'b0, stall_f}, 2'b00);
    tick();
    applyStimulus(nop, 0, 0, 0);
    @(negedge clk); checkOutput();
    checkSig("tp_r0_fwd", {fwd_a_e, fwd_b_e} == 4'b0000 ? 2'b00 : 2'b11, 2'b00);
    tick();

`ifndef HAZ_EARLY_BRANCH_EN
    // taken branch in M beats a simultaneous load-use stall
    step(mk(1, 2, 0, 1, 0, 8, 1, 1), 0, 0, 0);
    applyStimulus(mk(1, 8, 3, 1, 1, 9, 1, 0), 0, 1, 0);
    @(negedge clk); checkOutput();
    checkSig("tp_br_flush_de", {flush_d, flush_e}, 2'b11);
    checkSig("tp_br_flush_m_stall", {flush_m, stall_f}, 2'b10);
    tick();
`else
    // add $8 then beq $8,$9: one stall, then comparator forward from M
    step(mk(1, 1, 2, 1, 1, 8, 1, 0), 0, 0, 0);
    ins = mk(1, 8, 9, 1, 1, 0, 0, 0);
    applyStimulus(ins, 1, 0, 0);
    @(negedge clk); checkOutput();
    checkSig("tp_eb_stall", {stall_f, flush_e}, 2'b11);
    tick();
    applyStimulus(ins, 1, 0, 0);
    @(negedge clk); checkOutput();
    checkSig("tp_eb_fwd", {stall_f, fwd_a_d}, 2'b01);
    tick();
    applyStimulus(nop, 0, 1, 0);
    @(negedge clk); checkOutput();
    checkSig("tp_eb_pcsrc", {flush_d, flush_e}, 2'b10);
    tick();
`endif

    // reset in the middle of a pending load-use clears all history
    step(mk(1, 2, 0, 1, 0, 8, 1, 1), 0, 0, 0);
    ins = mk(1, 8, 8, 1, 1, 9, 1, 0);
    applyStimulus(ins, 0, 0, 1);
    @(negedge clk); checkOutput();
    checkSig("tp_rst_quiet", {stall_f, flush_e}, 2'b00);
    tick();
    applyStimulus(ins, 0, 0, 0);
    @(negedge clk); checkOutput();
    checkSig("tp_rst_nostale", {1'b0, stall_f}, 2'b00);
    tick();
    applyStimulus(nop, 0, 0, 0);
    @(negedge clk); checkOutput();
    checkSig("tp_rst_fwd", fwd_a_e, 2'b00);
    tick();

    // random streams over a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      bit br, pcs, rst;
      if (!e_stall || cur_rst) begin
        ins = mk($urandom_range(0, 7) != 0,
                 $urandom_range(0, 4), $urandom_range(0, 4),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 4), $urandom_range(0, 3) != 0, 1'b0);
        ins.mtr = ins.rw && ($urandom_range(0, 2) == 0);
        br = ($urandom_range(0, 3) == 0);
      end else begin
        ins = cur;
        br  = cur_br;
      end
      pcs = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 49) == 0);
      step(ins, br, pcs, rst);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
